// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port unified memory
// Data has priority; fetch is forced through after STARVE_LIMIT lost contended cycles.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]             starve_cnt;
    logic                   contended;
    logic                   d_win;
    logic                   resp_valid;
    logic [MEM_LATENCY-1:0] pipe_valid;
    logic [MEM_LATENCY-1:0] pipe_owner;

    always_comb begin
        contended = if_req && d_req;
        d_win     = d_req && (!if_req || (starve_cnt < LIMIT));
        // Gating with rst keeps every output at zero while reset is held.
        d_gnt     = rst && d_win;
        if_gnt    = rst && if_req && !d_win;
        mem_en    = if_gnt || d_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_we ? d_be : 4'hF;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_be    = 4'hF;
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'h0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= 4'h0;
        end else if (contended && d_gnt && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'h1;
        end
    end

    // Owner pipeline is latency-matched to the memory; stores enter as bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            pipe_valid[0] <= mem_en && !mem_we;
            pipe_owner[0] <= d_gnt;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    always_comb begin
        resp_valid = rst && pipe_valid[MEM_LATENCY-1];
        if_rvalid  = resp_valid && !pipe_owner[MEM_LATENCY-1];
        d_rvalid   = resp_valid && pipe_owner[MEM_LATENCY-1];
        if_rdata   = if_rvalid ? mem_rdata : 32'h0;
        d_rdata    = d_rvalid ? mem_rdata : 32'h0;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single-port unified memory between the instruction-fetch requester and the data (load/store) requester.
- Grants at most one access per cycle and drives the memory port.
- Tracks in-flight reads through a latency-matched owner pipeline and routes each read response back to the requester that issued it.
- Data accesses have priority; a starvation guard guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (1..4).
- STARVE_LIMIT, 4, consecutive contended cycles lost by fetch before fetch is forced to win (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch read request; held with stable if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch byte address, word aligned.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held with stable fields until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid; never asserted for stores.
- d_rdata  out  32  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en with mem_we=0.

Behaviour:
- Grant logic is combinational from the requests and the registered starvation state. Memory outputs are driven in the same cycle as the grant. Zero-cycle arbitration latency.
- Only d_req: d_gnt=1. Only if_req: if_gnt=1. Neither: no grant, mem_en=0, and mem_addr, mem_wdata, mem_be, mem_we are all 0.
- Both requesting (contended):
  - d wins if starve_cnt < STARVE_LIMIT.
  - Otherwise if wins.
  - At most one gnt is high in any cycle.
- Fetch grant drives mem_we=0, mem_be=4'hF, mem_addr=if_addr, mem_wdata=0.
- Data grant drives mem_we=d_we, mem_be = d_we ? d_be : 4'hF, mem_addr=d_addr, mem_wdata=d_wdata.
- starve_cnt (4 bits):
  - Increments by 1 on a contended cycle where d wins. Saturates at STARVE_LIMIT.
  - Clears to 0 on any cycle where if_gnt=1 or if_req=0.
  - Otherwise holds.
- Owner pipeline: MEM_LATENCY stages. Each stage holds {valid, owner} with owner 0=fetch, 1=data.
  - Stage 0 loads valid = (read granted this cycle) and owner = (d_gnt).
  - Stores enter as invalid entries.
  - Stages shift every cycle; there is no backpressure, and requesters always accept responses.
- Response routing: when the last stage is valid, mem_rdata goes to the owner's rdata and that owner's rvalid is pulsed for 1 cycle.
  - The non-owner's rdata is 0.
  - Read-response latency = MEM_LATENCY cycles after gnt.
- Back-to-back: a new grant is allowed every cycle, including while responses are in flight. Responses return in grant order.
- Reset (rst=0, async):
  - starve_cnt=0 and all pipeline valids cleared. In-flight responses are discarded and never produce rvalid.
  - Outputs while in reset: if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Requests are ignored during reset.
- After rst returns high, arbitration resumes on the first edge with normal grant rules.

Test Plan:
- Reset: rst=0 mid-stream with a fetch read granted the previous cycle, MEM_LATENCY=2 -> all outputs 0; after release, no if_rvalid for the discarded read.
- Fetch only: if_req=1, if_addr=0x44; memory word 0x00000073 -> if_gnt=1 in the same cycle, mem_addr=0x44, if_rvalid=1 with if_rdata=0x00000073 exactly MEM_LATENCY cycles later.
- Data store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_be=4'b0011; d_rvalid never asserts.
- Contention with default STARVE_LIMIT=4: if_req and d_req both held high -> d wins 4 cycles, if wins the 5th, then d wins the next 4; repeating 4:1 pattern, with gnts never simultaneously high.
- Back-to-back reads: alternating fetch 0x0 and load 0x100 each cycle with MEM_LATENCY=3 -> rvalids return in grant order on the correct port with matching data, one response per cycle.
- Starvation clear: contention for 3 cycles, then if_req=0 for 1 cycle, then contention again -> counter restarts, and d wins 4 more cycles before if is granted.
